// File: rtl/exe_multdiv_unit_pkg.sv
// Shared constants for the EXE multiply/divide engine: state encoding,
// datapath widths and the exception cause codes used alongside it.
package exe_multdiv_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = DATA_W;
  localparam int CNT_W      = 6;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/radix2_unsigned_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// done is high during the last step; quotient/remainder are final the cycle after.
module radix2_unsigned_divider
  import exe_multdiv_unit_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] dvsr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;

  logic [DATA_W:0]   shifted_s;
  logic [DATA_W-1:0] diff_s;
  logic [DATA_W-1:0] rem_next_s;
  logic              q_bit_s;

  // Trial subtract of the 33-bit shifted partial remainder; restore on borrow.
  always_comb begin
    shifted_s  = {rem_r, quo_r[DATA_W-1]};
    diff_s     = shifted_s[DATA_W-1:0] - dvsr_r;
    q_bit_s    = 1'b0;
    rem_next_s = shifted_s[DATA_W-1:0];
    if (shifted_s >= {1'b0, dvsr_r}) begin
      q_bit_s    = 1'b1;
      rem_next_s = diff_s;
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = shifted_s[DATA_W-1:0];
    end
  end

  // Iteration registers; the quotient register doubles as the dividend shifter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_r  <= {DATA_W{1'b0}};
      quo_r  <= {DATA_W{1'b0}};
      dvsr_r <= {DATA_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (abort) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= {DATA_W{1'b0}};
      quo_r  <= dividend;
      dvsr_r <= divisor;
      cnt_r  <= CNT_DIV;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r  <= rem_next_s;
      quo_r  <= {quo_r[DATA_W-2:0], q_bit_s};
      cnt_r  <= cnt_r - CNT_ONE;
      busy_r <= (cnt_r != CNT_ONE);
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign busy      = busy_r;
  assign done      = busy_r & (cnt_r == CNT_ONE);
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/exe_multdiv_unit.sv
// EXE-stage multiply/divide engine producing HI/LO; stalls the pipeline
// while an operation is in flight and pulses o_done when the result lands.
module exe_multdiv_unit
  import exe_multdiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_start,
  input  logic              i_is_div,
  input  logic              i_is_unsigned,
  input  logic [DATA_W-1:0] i_opr1,
  input  logic [DATA_W-1:0] i_opr2,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  md_state_e         state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] op_a_r;
  logic [DATA_W-1:0] op_b_r;
  logic              uns_r;
  logic              q_neg_r;
  logic              r_neg_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic              done_r;

  logic              accept_s;
  logic              sgn_a_s;
  logic              sgn_b_s;
  logic [DATA_W-1:0] mag_a_s;
  logic [DATA_W-1:0] mag_b_s;
  logic [2*DATA_W-1:0] prod_s;
  logic              div_busy_s;
  logic              div_done_s;
  logic [DATA_W-1:0] div_quo_s;
  logic [DATA_W-1:0] div_rem_s;

  assign accept_s = (state_r == ST_IDLE) & i_start & ~i_flush;
  assign sgn_a_s  = ~i_is_unsigned & i_opr1[DATA_W-1];
  assign sgn_b_s  = ~i_is_unsigned & i_opr2[DATA_W-1];
  assign mag_a_s  = cond_neg(i_opr1, sgn_a_s);
  assign mag_b_s  = cond_neg(i_opr2, sgn_b_s);

  // 33x33 signed/unsigned product; low 64 bits of the extended operands suffice.
  always_comb begin
    prod_s = {{DATA_W{~uns_r & op_a_r[DATA_W-1]}}, op_a_r} *
             {{DATA_W{~uns_r & op_b_r[DATA_W-1]}}, op_b_r};
  end

  radix2_unsigned_divider u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept_s & i_is_div),
    .abort     (i_flush),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .busy      (div_busy_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Control FSM with registered result and done pulse; flush overrides everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_a_r  <= {DATA_W{1'b0}};
      op_b_r  <= {DATA_W{1'b0}};
      uns_r   <= 1'b0;
      q_neg_r <= 1'b0;
      r_neg_r <= 1'b0;
      hi_r    <= {DATA_W{1'b0}};
      lo_r    <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
    end else if (i_flush) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            op_a_r  <= i_opr1;
            op_b_r  <= i_opr2;
            uns_r   <= i_is_unsigned;
            q_neg_r <= sgn_a_s ^ sgn_b_s;
            r_neg_r <= sgn_a_s;
            state_r <= i_is_div ? ST_DIV : ST_MUL;
            cnt_r   <= i_is_div ? CNT_DIV : CNT_W'(MULT_CYCLES);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == CNT_ONE) begin
            hi_r    <= prod_s[2*DATA_W-1:DATA_W];
            lo_r    <= prod_s[DATA_W-1:0];
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DIV: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (div_done_s || !div_busy_s) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_FIX: begin
          hi_r    <= cond_neg(div_rem_s, r_neg_r);
          lo_r    <= cond_neg(div_quo_s, q_neg_r);
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_stall = resetn & ~i_flush &
                   (((state_r == ST_IDLE) & i_start) |
                    (state_r == ST_MUL) | (state_r == ST_DIV) | (state_r == ST_FIX));
  assign o_done  = done_r;
  assign o_hi    = hi_r;
  assign o_lo    = lo_r;

endmodule

// File: tb/tb_exe_multdiv_unit.sv
// Directed-vector bench for exe_multdiv_unit: latency, stall shape, results,
// flush abort and asynchronous reset mid-operation.
module tb_exe_multdiv_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_start = 1'b0;
  logic        i_is_div = 1'b0;
  logic        i_is_unsigned = 1'b0;
  logic [31:0] i_opr1 = 32'h0;
  logic [31:0] i_opr2 = 32'h0;
  logic        i_flush = 1'b0;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_vec = 0;
  int n_bad = 0;

  exe_multdiv_unit #(.MULT_CYCLES(2)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .i_start       (i_start),
    .i_is_div      (i_is_div),
    .i_is_unsigned (i_is_unsigned),
    .i_opr1        (i_opr1),
    .i_opr2        (i_opr2),
    .i_flush       (i_flush),
    .o_stall       (o_stall),
    .o_done        (o_done),
    .o_hi          (o_hi),
    .o_lo          (o_lo)
  );

  initial forever #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current cycle and hold it until its DONE cycle.
  task automatic run_op(input string tag, input logic dv, input logic uns,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    i_start = 1'b1; i_is_div = dv; i_is_unsigned = uns; i_opr1 = a; i_opr2 = b;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check_value({tag, "_stall"}, 64'(o_stall), 64'(k < lat));
      check_value({tag, "_done"},  64'(o_done),  64'(k == lat));
      if (k == lat) begin
        check_value({tag, "_hi"}, 64'(o_hi), 64'(exp_hi));
        check_value({tag, "_lo"}, 64'(o_lo), 64'(exp_lo));
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_hi",    64'(o_hi),    64'h0);
    check_value("rst_lo",    64'(o_lo),    64'h0);
    check_value("rst_done",  64'(o_done),  64'h0);
    i_start = 1'b1; #1;
    check_value("rst_stall", 64'(o_stall), 64'h0);
    i_start = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("mult_m3x5",  1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005, 3, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max",  1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_b2b",   1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 3, 32'h3FFFFFFF, 32'h00000001);
    run_op("div_m7_2",   1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000);
    run_op("div_m5_0",   1'b1, 1'b0, 32'hFFFFFFFB, 32'h00000000, 34, 32'hFFFFFFFB, 32'h00000001);
    run_op("divu_5_0",   1'b1, 1'b1, 32'h00000005, 32'h00000000, 34, 32'h00000005, 32'hFFFFFFFF);
    run_op("divu_100_7", 1'b1, 1'b1, 32'd100,      32'd7,        34, 32'd2,        32'd14);

    // Flush a divide at T+10; it must vanish without touching HI/LO.
    i_start = 1'b1; i_is_div = 1'b1; i_is_unsigned = 1'b1; i_opr1 = 32'd1000; i_opr2 = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_value("flush_pre_stall", 64'(o_stall), 64'h1);
      @(posedge clk); #1;
    end
    i_flush = 1'b1;
    @(negedge clk);
    check_value("flush_stall", 64'(o_stall), 64'h0);
    @(posedge clk); #1;
    i_flush = 1'b0; i_start = 1'b0; #1;
    check_value("flush_idle_stall", 64'(o_stall), 64'h0);
    check_value("flush_no_done",    64'(o_done),  64'h0);
    check_value("flush_hi",         64'(o_hi),    64'd2);
    check_value("flush_lo",         64'(o_lo),    64'd14);
    run_op("mult_after_flush", 1'b0, 1'b0, 32'd6, 32'd7, 3, 32'd0, 32'd42);

    // Asynchronous reset in the middle of a divide.
    i_start = 1'b1; i_is_div = 1'b1; i_is_unsigned = 1'b0; i_opr1 = 32'd1000; i_opr2 = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0; #1;
    check_value("arst_hi",    64'(o_hi),    64'h0);
    check_value("arst_lo",    64'(o_lo),    64'h0);
    check_value("arst_done",  64'(o_done),  64'h0);
    check_value("arst_stall", 64'(o_stall), 64'h0);
    i_start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_value("post_rst_stall", 64'(o_stall), 64'h0);
      check_value("post_rst_done",  64'(o_done),  64'h0);
      @(posedge clk); #1;
    end
    run_op("multu_post_rst", 1'b0, 1'b1, 32'h00010000, 32'h00010000, 3, 32'h00000001, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
